// File: rtl/mips_breg_dump_if.sv
// mips_breg_dump_if
// Output stream of the register-file dumper: one (register number, value)
// beat per transfer, with a valid/ready handshake.
//   out_valid  master -> slave  beat available
//   out_ready  slave  -> master beat accepted on this edge
//   out_addr   master -> slave  register number of the beat
//   out_data   master -> slave  register value of the beat
interface mips_breg_dump_if #(
    parameter int WSIZE = 32
);
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_addr;
    logic [WSIZE-1:0] out_data;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/mips_breg_dump.sv
// mips_breg_dump
// Walks all 32 GPRs through the register file's two read ports, one
// even/odd pair at a time, and streams each (address, value) over the
// dump interface while keeping a running checksum of the emitted values.
// Ports:
//   clock, reset          system clock, async active-high reset
//   start, skip_zero      dump request (IDLE only) and zero-suppression option
//   readADDR1/readADDR2   register-file read addresses (even/odd of a pair)
//   Reg1/Reg2             register-file read data
//   dump                  output beat stream (master side)
//   busy, done            dump in progress / one-cycle completion pulse
//   checksum              sum of all transferred values, mod 2^WSIZE
//
// state | meaning
// IDLE  | waiting for start
// FETCH | read addresses driven, pair captured on the edge
// DRAIN | presenting the captured pair, b0 before b1
// DONE  | one-cycle done pulse
module mips_breg_dump #(
    parameter int WSIZE = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             skip_zero,
    output logic [4:0]       readADDR1,
    output logic [4:0]       readADDR2,
    input  logic [WSIZE-1:0] Reg1,
    input  logic [WSIZE-1:0] Reg2,
    mips_breg_dump_if.master dump,
    output logic             busy,
    output logic             done,
    output logic [WSIZE-1:0] checksum
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t           state;
    logic [3:0]       p;
    logic [WSIZE-1:0] b0;
    logic [WSIZE-1:0] b1;
    logic             v0;
    logic             v1;
    logic             skz;

    logic             sel_b1;
    logic [WSIZE-1:0] cur_data;
    logic             new_v0;
    logic             new_v1;

    // In DRAIN at least one entry is valid, so b1 is presented only once b0 is gone.
    assign sel_b1   = !v0;
    assign cur_data = sel_b1 ? b1 : b0;
    assign new_v0   = !(skz && (Reg1 == '0));
    assign new_v1   = !(skz && (Reg2 == '0));

    // Outputs decode registered state only; nothing depends combinationally on out_ready.
    assign dump.out_valid = (state == DRAIN);
    assign dump.out_addr  = (state == DRAIN) ? {p, sel_b1} : 5'd0;
    assign dump.out_data  = (state == DRAIN) ? cur_data : '0;
    assign readADDR1      = (state == FETCH) ? {p, 1'b0} : 5'd0;
    assign readADDR2      = (state == FETCH) ? {p, 1'b1} : 5'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            p        <= '0;
            b0       <= '0;
            b1       <= '0;
            v0       <= 1'b0;
            v1       <= 1'b0;
            skz      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            checksum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= FETCH;
                        p        <= '0;
                        checksum <= '0;
                        skz      <= skip_zero;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    b0 <= Reg1;
                    b1 <= Reg2;
                    v0 <= new_v0;
                    v1 <= new_v1;
                    if (new_v0 || new_v1) begin
                        state <= DRAIN;
                    end else if (p == 4'hF) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        p <= p + 4'd1;
                    end
                end
                DRAIN: begin
                    if (dump.out_ready) begin
                        checksum <= checksum + cur_data;
                        if (sel_b1) v1 <= 1'b0;
                        else        v0 <= 1'b0;
                        // Last entry of the pair: b1 just went, or b0 went with b1 empty.
                        if (sel_b1 || !v1) begin
                            if (p == 4'hF) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= FETCH;
                                p     <= p + 4'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_breg_dump.sv
module tb_mips_breg_dump;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        skip_zero = 1'b0;
    logic [4:0]  readADDR1, readADDR2;
    logic [31:0] Reg1, Reg2;
    logic        busy, done;
    logic [31:0] checksum;
    logic [31:0] gpr [0:31];

    mips_breg_dump_if #(.WSIZE(32)) ob ();

    mips_breg_dump #(.WSIZE(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .skip_zero (skip_zero),
        .readADDR1 (readADDR1),
        .readADDR2 (readADDR2),
        .Reg1      (Reg1),
        .Reg2      (Reg2),
        .dump      (ob.master),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    assign Reg1 = gpr[readADDR1];
    assign Reg2 = gpr[readADDR2];

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int beats_seen = 0;
    int done_cnt = 0;
    int rdy_mode = 0;
    logic [36:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // out_ready driver: 0 = always ready, 1 = 1-on/2-off, 2 = ready until 10 beats then stall
    initial begin
        int rcyc;
        rcyc = 0;
        ob.out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                0: ob.out_ready = 1'b1;
                1: begin
                    ob.out_ready = (rcyc % 3 == 0);
                    rcyc++;
                end
                default: ob.out_ready = (beats_seen < 10);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every transfer, checks stall stability.
    initial begin
        logic        stalled;
        logic [4:0]  s_addr;
        logic [31:0] s_data;
        logic [36:0] e;
        stalled = 1'b0;
        s_addr = '0;
        s_data = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (stalled)
                    chk("stall_hold", {ob.out_valid, ob.out_addr, ob.out_data},
                        {1'b1, s_addr, s_data});
                if (ob.out_valid) begin
                    if (ob.out_ready) begin
                        stalled = 1'b0;
                        beats_seen++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            checks++;
                            $display("FAIL unexpected_beat: got addr %0d data %h expected none",
                                     ob.out_addr, ob.out_data);
                        end else begin
                            e = exp_q.pop_front();
                            chk("beat", {ob.out_addr, ob.out_data}, e);
                        end
                    end else begin
                        stalled = 1'b1;
                        s_addr = ob.out_addr;
                        s_data = ob.out_data;
                    end
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    task automatic push_all(input bit skz);
        for (int i = 0; i < 32; i++)
            if (!(skz && gpr[i] == 32'h0)) exp_q.push_back({i[4:0], gpr[i]});
    endtask

    task automatic do_start(input bit skz);
        beats_seen = 0;
        done_cnt = 0;
        @(posedge clock);
        #1;
        start = 1'b1;
        skip_zero = skz;
        @(posedge clock);   // E0
        #1;
        start = 1'b0;
        skip_zero = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cycles, input logic [31:0] exp_sum);
        int n;
        bit ok;
        n = 0;
        ok = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clock);
            if (done) begin
                ok = 1;
                break;
            end
            @(posedge clock);
            n++;
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got no done expected done within 2000 cycles", name);
        end else begin
            if (exp_cycles >= 0) chk({name, "_cycles"}, n, exp_cycles);
            chk({name, "_busy_at_done"}, busy, 1'b1);
            chk({name, "_checksum"}, checksum, exp_sum);
        end
        repeat (4) @(posedge clock);
        @(negedge clock);
        chk({name, "_idle_busy"}, busy, 1'b0);
        chk({name, "_done_pulses"}, done_cnt, 1);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        chk({name, "_checksum_hold"}, checksum, exp_sum);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 32; i++) gpr[i] = i * 32'h11;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) gpr[i] = 32'h0;
        #22;
        chk("reset_valid", ob.out_valid, 1'b0);
        chk("reset_addr", ob.out_addr, 5'd0);
        chk("reset_data", ob.out_data, 32'h0);
        chk("reset_busy_done", {busy, done}, 2'b00);
        chk("reset_checksum", checksum, 32'h0);
        chk("reset_raddr", {readADDR1, readADDR2}, 10'h0);
        @(negedge clock);
        reset = 1'b0;

        // 1: full ramp dump, always ready
        load_ramp();
        rdy_mode = 0;
        push_all(0);
        do_start(0);
        wait_done("ramp", 48, 32'h20F0);

        // 2: same with 1-on/2-off ready
        rdy_mode = 1;
        push_all(0);
        do_start(0);
        wait_done("ramp_stall", -1, 32'h20F0);
        rdy_mode = 0;

        // 3: sparse registers with skip_zero
        for (int i = 0; i < 32; i++) gpr[i] = 32'h0;
        gpr[5] = 32'hDEADBEEF;
        gpr[31] = 32'h1;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        exp_q.push_back({5'd31, 32'h1});
        do_start(1);
        wait_done("sparse", 18, 32'hDEADBEF0);

        // 4: start re-pulsed at beat 3 is ignored
        load_ramp();
        push_all(0);
        fork
            do_start(0);
            begin
                for (int k = 0; k < 200 && beats_seen < 3; k++) @(negedge clock);
                chk("restart_reached_beat3", beats_seen >= 3, 1'b1);
                @(posedge clock);
                #1;
                start = 1'b1;
                @(posedge clock);
                #1;
                start = 1'b0;
            end
        join
        wait_done("restart", -1, 32'h20F0);

        // 5: reset while beat 10 stalls, then a clean full dump
        rdy_mode = 2;
        push_all(0);
        do_start(0);
        begin
            bit hit;
            hit = 0;
            for (int k = 0; k < 500; k++) begin
                @(negedge clock);
                if (ob.out_valid && !ob.out_ready && ob.out_addr == 5'd10) begin
                    hit = 1;
                    break;
                end
            end
            chk("stall_at_beat10", hit, 1'b1);
        end
        @(negedge clock);
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_valid", ob.out_valid, 1'b0);
        chk("abort_addr_data", {ob.out_addr, ob.out_data}, 37'h0);
        chk("abort_busy_done", {busy, done}, 2'b00);
        chk("abort_checksum", checksum, 32'h0);
        chk("abort_raddr", {readADDR1, readADDR2}, 10'h0);
        repeat (2) @(negedge clock);
        exp_q.delete();
        rdy_mode = 0;
        reset = 1'b0;
        push_all(0);
        do_start(0);
        wait_done("after_reset", 48, 32'h20F0);

        // 6: all ones, checksum wraps
        for (int i = 0; i < 32; i++) gpr[i] = 32'hFFFFFFFF;
        gpr[0] = 32'h0;
        push_all(0);
        do_start(0);
        wait_done("wrap", 48, 32'hFFFFFFE1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mips_breg_dump.md
# mips_breg_dump

Sequential register-file reader for the MIPS datapath. On a start pulse it walks all 32 general-purpose registers through the register file's two combinational read ports and streams each (address, value) pair out over a valid/ready handshake. It also accumulates a running checksum of the emitted values. It sits beside the register file as a debug and test-harness port, and drives the read-address side while the processor is halted.

## Interface
- WSIZE, 32, data width; must match the register file word width.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- skip_zero  in  1  when 1, registers whose value is zero are not emitted; sampled together with start.
- readADDR1  out  5  register-file read address, port 1 (even register of the current pair).
- readADDR2  out  5  register-file read address, port 2 (odd register of the current pair).
- Reg1  in  WSIZE  register-file read data, port 1 (combinational response to readADDR1).
- Reg2  in  WSIZE  register-file read data, port 2 (combinational response to readADDR2).
- out_valid  out  1  output beat available.
- out_ready  in  1  consumer accepts the beat; transfer occurs when out_valid && out_ready at a clock edge.
- out_addr  out  5  register number of the current beat.
- out_data  out  WSIZE  register value of the current beat.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final transfer.
- checksum  out  WSIZE  sum mod 2^WSIZE of all transferred out_data; held until the next accepted start.

## Operation
- The state machine has four states: IDLE, FETCH, DRAIN and DONE. It holds a pair index p (0..15) and a 2-entry capture buffer, b0 and b1, each with a valid flag.
- IDLE: busy=0, out_valid=0, readADDR1=readADDR2=0.
  - start=1 goes to FETCH.
  - On that edge: p=0, checksum=0, and skip_zero is latched as skz.
- FETCH:
  - Drive readADDR1={p,1'b0} and readADDR2={p,1'b1}.
  - On the edge, capture b0=Reg1 and b1=Reg2.
  - Each entry's valid flag = !(skz && value==0).
  - If at least one entry is valid, go to DRAIN.
  - If neither is valid, skip DRAIN: go to FETCH with p+1, or to DONE if p==15.
- DRAIN:
  - out_valid=1. Present b0 if it is valid, otherwise b1. out_addr = {p,0} for b0 and {p,1} for b1.
  - On each transfer, clear the presented entry and add its data to checksum (wraps mod 2^WSIZE).
  - When the last valid entry transfers: if p==15 go to DONE, otherwise set p=p+1 and go to FETCH.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE. checksum holds its final value.
- start while not in IDLE is ignored. skip_zero is ignored outside the start-accept edge.
- Each pair is a snapshot taken at its FETCH edge. There is no coherence guarantee across pairs if the register file is written during a dump.
- Register 0 always reads zero, so with skz=1 it is never emitted.

## Timing
- Reset values: IDLE, p=0, b0/b1 invalid, out_valid=0, out_addr=0, out_data=0, readADDR1=readADDR2=0, busy=0, done=0, checksum=0.
- Reset mid-dump aborts immediately. No further beats are emitted, and a new start restarts from register 0.
- The start-accept edge is E0. FETCH occurs in the cycle after E0. The first out_valid is high in the cycle after E1.
- With out_ready held at 1 and skz=0, each pair takes 3 edges. The last transfer is at E48, done is high in the cycle after E48, and the block is back in IDLE after E49.
- While out_valid && !out_ready, out_valid, out_addr and out_data are held stable. out_valid never deasserts without a transfer, except on reset.
- A pair skipped entirely under skz costs 1 cycle (FETCH only).
- busy and done are registered outputs. readADDR1/readADDR2 are registered or state-decoded, with no combinational path from out_ready.

## Test plan
- Load GPR[i]=i*32'h11 (so GPR0=0). Pulse start with skip_zero=0 and out_ready=1 → 32 beats, addr 0..31 in order, data i*0x11; done in the cycle after E48; checksum=32'h20F0.
- Same load, with out_ready toggling in a 1-on/2-off pattern → identical beat sequence and checksum. out_addr/out_data remain unchanged across every stalled cycle.
- Only r5=32'hDEADBEEF and r31=1 are nonzero; skip_zero=1 → exactly 2 beats, (5, DEADBEEF) then (31, 1); checksum=32'hDEADBEF0; total dump time 16 FETCH cycles plus 2 DRAIN cycles.
- Pulse start again at beat 3 of a running dump → ignored; the beat sequence and checksum are unchanged, and exactly one done pulse is produced.
- Assert reset while beat 10 is stalled → all outputs go to reset values within the same cycle. A subsequent start yields a full dump beginning at addr 0 with checksum recomputed from 0.
- All registers = 32'hFFFFFFFF, skip_zero=0 (GPR0=0) → 32 beats; checksum wraps to 31*0xFFFFFFFF mod 2^32 = 32'hFFFFFFE1.
